// File: rtl/clint_cmp_scheduler_pkg.sv
// Shared types and CLINT register offsets for the mtimecmp deadline scheduler.
package clint_cmp_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_W_LO_MAX,
    S_W_HI,
    S_W_LO
  } state_e;

  localparam logic [15:0] MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] TGT_NONE = '1;

  function automatic logic [31:0] clint_addr(input logic [31:0] base, input logic [15:0] off);
    return base + {16'h0000, off};
  endfunction

endpackage

// File: rtl/clint_cmp_scheduler_if.sv
// CLINT write-port handshake between the scheduler (master) and the bus mux (slave).
interface clint_cmp_scheduler_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;

  modport master (output bus_req, bus_addr, bus_wdata, bus_wstrb, input bus_gnt);
  modport slave  (input bus_req, bus_addr, bus_wdata, bus_wstrb, output bus_gnt);
endinterface

// File: rtl/clint_cmp_scheduler_cmp_min_tree.sv
// Combinational earliest-deadline search over armed slots; ties resolve to the lowest index.
module cmp_min_tree #(
  parameter int unsigned NSLOT = 4
) (
  input  logic [NSLOT-1:0]           armed,
  input  logic [NSLOT-1:0][63:0]     deadline,
  output logic [$clog2(NSLOT)-1:0]   min_idx,
  output logic                       any_armed
);

  localparam int unsigned IW = $clog2(NSLOT);

  logic [63:0] best_val;

  always_comb begin
    best_val  = '1;
    min_idx   = '0;
    any_armed = 1'b0;
    // Strict less-than keeps the earlier (lower) index on equal deadlines
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (armed[i] && (!any_armed || (deadline[i] < best_val))) begin
        any_armed = 1'b1;
        best_val  = deadline[i];
        min_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/clint_cmp_scheduler.sv
// Tracks NSLOT absolute mtime deadlines and reprograms CLINT mtimecmp with the earliest one.
module clint_cmp_scheduler
  import clint_cmp_scheduler_pkg::*;
#(
  parameter int unsigned NSLOT      = 4,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(NSLOT)-1:0] cfg_slot,
  input  logic [63:0]              cfg_deadline,
  input  logic                     cfg_disarm,
  input  logic [NSLOT-1:0]         pend_clr,
  input  logic [63:0]              mtime_in,
  clint_cmp_scheduler_if.master    bus,
  output logic [NSLOT-1:0]         pending,
  output logic                     irq,
  output logic                     busy
);

  localparam int unsigned SW = $clog2(NSLOT);

  logic [NSLOT-1:0][63:0] deadline_q, deadline_d;
  logic [NSLOT-1:0]       armed_q, armed_d;
  logic [NSLOT-1:0]       pending_q, pending_d;
  logic [NSLOT-1:0]       expire;
  logic                   dirty_q, dirty_d;
  logic                   irq_q, irq_d;
  logic                   busy_q, busy_d;
  state_e                 state_q, state_d;
  logic [63:0]            tgt_q, tgt_d;
  logic                   bus_req_q, bus_req_d;
  logic [31:0]            bus_addr_q, bus_addr_d;
  logic [31:0]            bus_wdata_q, bus_wdata_d;
  logic [3:0]             bus_wstrb_q, bus_wstrb_d;
  logic                   enter_sel;
  logic [SW-1:0]          min_idx;
  logic                   any_armed;
  logic [63:0]            target;

  cmp_min_tree #(.NSLOT(NSLOT)) u_min_tree (
    .armed     (armed_q),
    .deadline  (deadline_q),
    .min_idx   (min_idx),
    .any_armed (any_armed)
  );

  assign target = any_armed ? deadline_q[min_idx] : TGT_NONE;

  always_comb begin
    deadline_d = deadline_q;
    armed_d    = armed_q;
    expire     = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      expire[i] = armed_q[i] && (mtime_in >= deadline_q[i]);
      if (cfg_we && (cfg_slot == SW'(i))) begin
        deadline_d[i] = cfg_deadline;
        armed_d[i]    = 1'b1;
      end else if (cfg_disarm && (cfg_slot == SW'(i))) begin
        armed_d[i] = 1'b0;
      end else if (expire[i]) begin
        armed_d[i] = 1'b0;
      end
    end
    // A same-cycle expiry beats write-1-to-clear so no deadline event is lost
    pending_d = expire | (pending_q & ~pend_clr);
    irq_d     = |pending_d;
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    enter_sel   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dirty_q) begin
          state_d   = S_SEL;
          enter_sel = 1'b1;
        end
      end
      S_SEL: begin
        tgt_d       = target;
        state_d     = S_W_LO_MAX;
        bus_req_d   = 1'b1;
        bus_addr_d  = clint_addr(CLINT_BASE, MTIMECMP_LO);
        bus_wdata_d = '1;
      end
      S_W_LO_MAX: begin
        if (bus.bus_gnt) begin
          state_d     = S_W_HI;
          bus_addr_d  = clint_addr(CLINT_BASE, MTIMECMP_HI);
          bus_wdata_d = tgt_q[63:32];
        end
      end
      S_W_HI: begin
        if (bus.bus_gnt) begin
          state_d     = S_W_LO;
          bus_addr_d  = clint_addr(CLINT_BASE, MTIMECMP_LO);
          bus_wdata_d = tgt_q[31:0];
        end
      end
      S_W_LO: begin
        if (bus.bus_gnt) begin
          bus_req_d   = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          if (dirty_q) begin
            state_d   = S_SEL;
            enter_sel = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        bus_req_d   = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
      end
    endcase
    // New events in the SEL-entry cycle must survive the clear to trigger a follow-up pass
    dirty_d     = cfg_we | cfg_disarm | (|expire) | (dirty_q & ~enter_sel);
    bus_wstrb_d = bus_req_d ? 4'hF : 4'h0;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deadline_q  <= '0;
      armed_q     <= '0;
      pending_q   <= '0;
      dirty_q     <= 1'b0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      state_q     <= S_IDLE;
      tgt_q       <= '1;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
    end else begin
      deadline_q  <= deadline_d;
      armed_q     <= armed_d;
      pending_q   <= pending_d;
      dirty_q     <= dirty_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_wstrb = bus_wstrb_q;
  assign pending       = pending_q;
  assign irq           = irq_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_clint_cmp_scheduler.sv
// Scoreboard bench: expected CLINT writes are queued by stimulus and popped by a bus monitor.
module tb_clint_cmp_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_slot = '0;
  logic [63:0] cfg_deadline = '0;
  logic        cfg_disarm = 1'b0;
  logic [3:0]  pend_clr = '0;
  logic [63:0] mtime_in = '0;
  logic [3:0]  pending;
  logic        irq;
  logic        busy;

  clint_cmp_scheduler_if bus ();

  clint_cmp_scheduler #(.NSLOT(4), .CLINT_BASE(32'h0200_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_slot     (cfg_slot),
    .cfg_deadline (cfg_deadline),
    .cfg_disarm   (cfg_disarm),
    .pend_clr     (pend_clr),
    .mtime_in     (mtime_in),
    .bus          (bus),
    .pending      (pending),
    .irq          (irq),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  wr_cyc_q[$];
  int  checks = 0;
  int  errors = 0;

  localparam logic [31:0] A_LO = 32'h0200_4000;
  localparam logic [31:0] A_HI = 32'h0200_4004;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_seq(input logic [63:0] t);
    push_wr(A_LO, 32'hFFFF_FFFF);
    push_wr(A_HI, t[63:32]);
    push_wr(A_LO, t[31:0]);
  endtask

  // Bus monitor: each completed handshake must match the head of the scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (!rst && bus.bus_req && bus.bus_gnt) begin
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.bus_addr, bus.bus_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.bus_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.bus_wdata), 64'(e.data));
        chk("wr_wstrb", 64'(bus.bus_wstrb), 64'h0F);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got busy=%0b queued=%0d expected idle with 0 queued", name, busy, exp_q.size());
  endtask

  task automatic wait_bus(input logic [31:0] a, input string name);
    for (int i = 0; i < 50; i++) begin
      if (bus.bus_req && bus.bus_addr == a) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got addr %h expected bus_req with addr %h", name, bus.bus_addr, a);
  endtask

  task automatic arm(input logic [1:0] s, input logic [63:0] d);
    cfg_we       = 1'b1;
    cfg_slot     = s;
    cfg_deadline = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_bus_req"},   64'(bus.bus_req),   64'h0);
    chk({tag, "_bus_addr"},  64'(bus.bus_addr),  64'h0);
    chk({tag, "_bus_wdata"}, 64'(bus.bus_wdata), 64'h0);
    chk({tag, "_bus_wstrb"}, 64'(bus.bus_wstrb), 64'h0);
    chk({tag, "_irq"},       64'(irq),           64'h0);
    chk({tag, "_busy"},      64'(busy),          64'h0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_disarm = 1'b0;
    pend_clr   = '0;
    bus.bus_gnt = 1'b1;
    tick();
    tick();
    chk_outputs_zero("reset");
    chk("reset_pending", 64'(pending), 64'h0);
    exp_q.delete();
    wr_cyc_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int a;
    logic [63:0] steps [4];

    // Basic arm: three back-to-back writes, 5-cycle latency, expiry at 1000
    do_reset();
    mtime_in = 64'd0;
    a = cyc;
    push_seq(64'd1000);
    arm(2'd0, 64'd1000);
    wait_idle("basic");
    chk("basic_wr_count", 64'(wr_cyc_q.size()), 64'd3);
    if (wr_cyc_q.size() >= 3) begin
      chk("basic_first_wr_cycle", 64'(wr_cyc_q[0] - a), 64'd3);
      chk("basic_last_wr_latency", 64'(wr_cyc_q[2] - a), 64'd5);
    end
    mtime_in = 64'd999;
    tick();
    tick();
    chk("basic_pending_before", 64'(pending), 64'h0);
    push_seq('1);
    mtime_in = 64'd1000;
    tick();
    chk("basic_pending_at", 64'(pending), 64'h1);
    chk("basic_irq_at", 64'(irq), 64'h1);
    wait_idle("basic_rearm");
    pend_clr = 4'b0001;
    tick();
    pend_clr = '0;
    chk("basic_pending_cleared", 64'(pending), 64'h0);
    chk("basic_irq_cleared", 64'(irq), 64'h0);

    // Earlier deadline arrives during W_HI: current sequence finishes, then reprograms
    do_reset();
    mtime_in = 64'd100;
    push_seq(64'd500);
    arm(2'd1, 64'd500);
    wait_bus(A_HI, "reprog_whi");
    push_seq(64'd300);
    arm(2'd2, 64'd300);
    wait_idle("reprog");
    chk("reprog_pending_before", 64'(pending), 64'h0);
    push_seq(64'd500);
    mtime_in = 64'd300;
    tick();
    chk("reprog_pending_slot2", 64'(pending), 64'h4);
    wait_idle("reprog_after");

    // Equal deadlines expire together; pend_clr on the expiry cycle is ignored
    do_reset();
    mtime_in = 64'd0;
    push_seq(64'd2000);
    arm(2'd0, 64'd2000);
    wait_idle("tie_a");
    push_seq(64'd2000);
    arm(2'd3, 64'd2000);
    wait_idle("tie_b");
    mtime_in = 64'd1999;
    tick();
    chk("tie_pending_before", 64'(pending), 64'h0);
    push_seq('1);
    mtime_in = 64'd2000;
    pend_clr = 4'b1001;
    tick();
    pend_clr = '0;
    chk("tie_pending_both", 64'(pending), 64'h9);
    wait_idle("tie_final");

    // Grant withheld for 7 cycles in W_HI: request held steady, no writes lost/repeated
    do_reset();
    bus.bus_gnt = 1'b0;
    mtime_in = 64'd0;
    push_seq(64'h0000_0003_1234_5678);
    arm(2'd1, 64'h0000_0003_1234_5678);
    wait_bus(A_LO, "stall_wlomax");
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("stall_req", 64'(bus.bus_req), 64'h1);
      chk("stall_addr", 64'(bus.bus_addr), 64'(A_HI));
      chk("stall_data", 64'(bus.bus_wdata), 64'h3);
      @(posedge clk);
      #1;
    end
    bus.bus_gnt = 1'b1;
    wait_idle("stall");
    chk("stall_wr_count", 64'(wr_cyc_q.size()), 64'd3);

    // 64-bit deadline across the 32-bit boundary: irq stays low until the real deadline
    do_reset();
    mtime_in = 64'h0000_0000_FFFF_FFF0;
    push_seq(64'h0000_0001_0000_0010);
    arm(2'd0, 64'h0000_0001_0000_0010);
    wait_idle("wide");
    steps[0] = 64'h0000_0000_FFFF_FFFF;
    steps[1] = 64'h0000_0001_0000_0000;
    steps[2] = 64'h0000_0001_0000_0001;
    steps[3] = 64'h0000_0001_0000_000F;
    for (int i = 0; i < 4; i++) begin
      mtime_in = steps[i];
      tick();
      chk("wide_irq_low", 64'(irq), 64'h0);
    end
    push_seq('1);
    mtime_in = 64'h0000_0001_0000_0010;
    tick();
    chk("wide_pending", 64'(pending), 64'h1);
    wait_idle("wide_final");

    // Reset in W_HI abandons the sequence; a later arm runs normally
    do_reset();
    mtime_in = 64'd0;
    push_wr(A_LO, 32'hFFFF_FFFF);
    arm(2'd0, 64'd1000);
    wait_bus(A_HI, "rst_whi");
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("midrst_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("midrst_wr_count", 64'(wr_cyc_q.size()), 64'd1);
    push_seq(64'd777);
    arm(2'd2, 64'd777);
    wait_idle("midrst_rearm");
    chk("midrst_rearm_wr_count", 64'(wr_cyc_q.size()), 64'd4);

    // Past deadline expires next cycle without any CLINT write; disarm and we-priority
    do_reset();
    bus.bus_gnt = 1'b0;
    mtime_in = 64'd5000;
    arm(2'd1, 64'd100);
    tick();
    chk("past_pending", 64'(pending), 64'h2);
    chk("past_irq", 64'(irq), 64'h1);
    cfg_we       = 1'b1;
    cfg_disarm   = 1'b1;
    cfg_slot     = 2'd0;
    cfg_deadline = 64'd6000;
    tick();
    cfg_we     = 1'b0;
    cfg_disarm = 1'b0;
    arm(2'd3, 64'd9000);
    cfg_disarm = 1'b1;
    cfg_slot   = 2'd3;
    tick();
    cfg_disarm = 1'b0;
    mtime_in = 64'd9000;
    tick();
    tick();
    chk("disarm_pending", 64'(pending), 64'h3);
    chk("past_no_writes", 64'(wr_cyc_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
